// File: rtl/jedro_1_ifu_prefetch.sv
// jedro_1_ifu_prefetch: sequential instruction prefetcher with a FIFO_DEPTH-entry buffer
// Ports: clk_i/rst_i clock and sync active-high reset; jmp_instr_i/jmp_address_i redirect;
// instr_o/instr_addr_o/instr_valid_o buffered head to the decoder, decoder_ready_i pops it;
// mem_en_o/mem_addr_o ROM request, mem_rdata_i ROM data one cycle after the request.
module jedro_1_ifu_prefetch #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  jmp_instr_i,
    input  logic [ADDR_WIDTH-1:0] jmp_address_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_valid_o,
    input  logic                  decoder_ready_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

    logic [ADDR_WIDTH-1:0] pc_q, pc_d, req_addr_q, req_addr_d;
    logic                  inflight_q, inflight_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] instr_buf_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] instr_buf_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_buf_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_buf_d [FIFO_DEPTH];
    logic                  pop, push, issue;
    logic [ADDR_WIDTH-1:0] jmp_target;
    logic [CW:0]           occupancy;

    assign jmp_target    = jmp_address_i & ~ADDR_WIDTH'(3);
    assign instr_valid_o = count_q != '0;
    assign instr_o       = instr_valid_o ? instr_buf_q[rd_ptr_q] : '0;
    assign instr_addr_o  = instr_valid_o ? addr_buf_q[rd_ptr_q] : '0;
    assign pop           = instr_valid_o & decoder_ready_i;
    assign push          = inflight_q & ~jmp_instr_i;
    // entries that will be held after this cycle's pop, counting the response still on its way
    assign occupancy     = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue         = ~rst_i & (jmp_instr_i | (occupancy < DEPTH_C));
    assign mem_en_o      = issue;
    assign mem_addr_o    = (jmp_instr_i & ~rst_i) ? jmp_target : pc_q;

    always_comb begin
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        inflight_d  = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        instr_buf_d = instr_buf_q;
        addr_buf_d  = addr_buf_q;
        if (jmp_instr_i) begin
            // flush drops the buffer and the response arriving now
            pc_d       = jmp_target + ADDR_WIDTH'(4);
            req_addr_d = jmp_target;
            inflight_d = 1'b1;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                instr_buf_d[wr_ptr_q] = mem_rdata_i;
                addr_buf_d[wr_ptr_q]  = req_addr_q;
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
            if (issue) begin
                pc_d       = pc_q + ADDR_WIDTH'(4);
                req_addr_d = pc_q;
                inflight_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= BOOT_ADDR;
            req_addr_q <= BOOT_ADDR;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        instr_buf_q <= instr_buf_d;
        addr_buf_q  <= addr_buf_d;
    end
endmodule
